// File: rtl/ahblite_gamma_lut.sv
// AHB-lite slave holding one programmable gamma LUT per colour channel, applied to a
// single-stage valid/ready pixel pipeline with frame-synchronous enable switching.
module ahblite_gamma_lut #(
    parameter int CH = 3,
    parameter int DW = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [3:0]       HPROT,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    input  logic             pix_in_sof,
    input  logic [CH*DW-1:0] pix_in_data,
    output logic             pix_out_valid,
    input  logic             pix_out_ready,
    output logic             pix_out_sof,
    output logic [CH*DW-1:0] pix_out_data
);
    localparam int DEPTH = 2**DW;

    logic             addr_valid_q, addr_valid_d;
    logic             write_q, write_d;
    logic [2:0]       region_q, region_d;
    logic [DW-1:0]    entry_q, entry_d;
    logic [CH-1:0]    en_cfg_q, en_cfg_d;
    logic [CH-1:0]    en_active_q, en_active_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic [CH*DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0]    lut_q [CH][DEPTH];

    logic             wr_commit;
    logic             accept;
    logic [CH-1:0]    lut_we;
    logic [CH-1:0]    en_eff;
    logic [CH*DW-1:0] corrected;
    logic [31:0]      rdata;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HPROT, HADDR[31:DW+5], HADDR[1:0], HTRANS[0], HWDATA[31:DW]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Address phase capture; held while another slave stretches the bus.
    always_comb begin
        addr_valid_d = addr_valid_q;
        write_d      = write_q;
        region_d     = region_q;
        entry_d      = entry_q;
        if (HREADY) begin
            addr_valid_d = HSEL & HTRANS[1];
            write_d      = HWRITE;
            region_d     = HADDR[DW+4:DW+2];
            entry_d      = HADDR[DW+1:2];
        end
    end

    assign wr_commit = addr_valid_q & write_q & HREADY;

    always_comb begin
        en_cfg_d = en_cfg_q;
        if (wr_commit && region_q == 3'd0 && entry_q[1:0] == 2'd0)
            en_cfg_d = HWDATA[CH-1:0];
    end

    assign pix_in_ready = ~out_valid_q | pix_out_ready;
    assign accept       = pix_in_valid & pix_in_ready;

    // The SOF beat already sees the freshly configured enables.
    assign en_eff = pix_in_sof ? en_cfg_q : en_active_q;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [DW-1:0] sample;
            assign sample     = pix_in_data[gi*DW +: DW];
            assign lut_we[gi] = wr_commit && (region_q == 3'(gi + 1));
            assign corrected[gi*DW +: DW] = en_eff[gi] ? lut_q[gi][sample] : sample;
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_data_d  = out_data_q;
        en_active_d = en_active_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sof_d   = pix_in_sof;
            out_data_d  = corrected;
            if (pix_in_sof)
                en_active_d = en_cfg_q;
        end else if (pix_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (region_q == 3'd0) begin
            if (entry_q[1:0] == 2'd0)
                rdata[CH-1:0] = en_cfg_q;
            else if (entry_q[1:0] == 2'd1)
                rdata[CH-1:0] = en_active_q;
        end else begin
            for (int c = 0; c < CH; c++)
                if (region_q == 3'(c + 1))
                    rdata[DW-1:0] = lut_q[c][entry_q];
        end
    end
    assign HRDATA = rdata;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_valid_q <= 1'b0;
            write_q      <= 1'b0;
            region_q     <= '0;
            entry_q      <= '0;
            en_cfg_q     <= '0;
            en_active_q  <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            addr_valid_q <= addr_valid_d;
            write_q      <= write_d;
            region_q     <= region_d;
            entry_q      <= entry_d;
            en_cfg_q     <= en_cfg_d;
            en_active_q  <= en_active_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_data_q   <= out_data_d;
        end
    end

    // Tables live in flops so that reset can restore the identity curve.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int c = 0; c < CH; c++)
                for (int i = 0; i < DEPTH; i++)
                    lut_q[c][i] <= DW'(i);
        end else begin
            for (int c = 0; c < CH; c++)
                if (lut_we[c])
                    lut_q[c][entry_q] <= HWDATA[DW-1:0];
        end
    end

    assign pix_out_valid = out_valid_q;
    assign pix_out_sof   = out_sof_q;
    assign pix_out_data  = out_data_q;
endmodule

// File: tb/tb_ahblite_gamma_lut.sv
// Directed bench for ahblite_gamma_lut: register access, LUT correction, frame-synchronous
// enables, backpressure, burst LUT programming, write/lookup collision and mid-run reset.
module tb_ahblite_gamma_lut;
    localparam int CH = 3;
    localparam int DW = 8;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic [3:0]       HPROT;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic [31:0]      HRDATA;
    logic             HRESP;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic             pix_in_sof;
    logic [CH*DW-1:0] pix_in_data;
    logic             pix_out_valid;
    logic             pix_out_ready;
    logic             pix_out_sof;
    logic [CH*DW-1:0] pix_out_data;

    int checks = 0;
    int passed = 0;

    localparam logic [31:0] A_CTRL   = 32'h0000;
    localparam logic [31:0] A_STATUS = 32'h0004;
    localparam logic [31:0] A_CH0    = 32'h0400;
    localparam logic [31:0] A_CH1    = 32'h0800;
    localparam logic [31:0] A_CH2    = 32'h0C00;
    localparam logic [31:0] A_BAD    = 32'h1000;

    ahblite_gamma_lut #(.CH(CH), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_sof(pix_in_sof),
        .pix_in_data(pix_in_data), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
        .pix_out_sof(pix_out_sof), .pix_out_data(pix_out_data)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic send_pix(input string name, input logic [CH*DW-1:0] data, input logic sof,
                            input logic [CH*DW-1:0] exp);
        pix_out_ready = 1'b1; pix_in_valid = 1'b1; pix_in_data = data; pix_in_sof = sof;
        tick();
        pix_in_valid = 1'b0; pix_in_sof = 1'b0;
        checks++;
        if (pix_out_valid !== 1'b1 || pix_out_data !== exp || pix_out_sof !== sof)
            $display("FAIL %s: got valid=%b data=%h sof=%b, expected valid=1 data=%h sof=%b",
                     name, pix_out_valid, pix_out_data, pix_out_sof, exp, sof);
        else passed++;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++;
        if (pix_out_valid !== 1'b0 || pix_out_data !== '0 || pix_out_sof !== 1'b0)
            $display("FAIL reset_pix: got valid=%b data=%h sof=%b, expected 0 0 0",
                     pix_out_valid, pix_out_data, pix_out_sof);
        else passed++;
        ahb_read(A_CTRL, r);
        checks++;
        if (r !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", r); else passed++;
        ahb_read(A_STATUS, r);
        checks++;
        if (r !== 32'h0) $display("FAIL reset_status: got %h expected 0", r); else passed++;
        ahb_read(A_CH0 | (32'h37 << 2), r);
        checks++;
        if (r !== 32'h37) $display("FAIL reset_lut: got %h expected 37", r); else passed++;
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
            $display("FAIL bus_resp: got hreadyout=%b hresp=%b expected 1 0", HREADYOUT, HRESP);
        else passed++;
    endtask

    task automatic test_lut_correction();
        logic [31:0] r;
        ahb_write(A_CH1 | (32'h10 << 2), 32'hA5);
        ahb_write(A_CTRL, 32'h2);
        ahb_read(A_CH1 | (32'h10 << 2), r);
        checks++;
        if (r !== 32'hA5) $display("FAIL lut_readback: got %h expected a5", r); else passed++;
        send_pix("sof_corrected", 24'h101010, 1'b1, 24'h10A510);
        ahb_read(A_STATUS, r);
        checks++;
        if (r !== 32'h2) $display("FAIL status_after_sof: got %h expected 2", r); else passed++;
    endtask

    task automatic test_midframe_ctrl();
        logic [31:0] r;
        ahb_write(A_CTRL, 32'h0);
        send_pix("midframe_still_corrected", 24'h101010, 1'b0, 24'h10A510);
        ahb_read(A_STATUS, r);
        checks++;
        if (r !== 32'h2) $display("FAIL status_midframe: got %h expected 2", r); else passed++;
        send_pix("next_sof_uncorrected", 24'h101010, 1'b1, 24'h101010);
        ahb_read(A_STATUS, r);
        checks++;
        if (r !== 32'h0) $display("FAIL status_new_frame: got %h expected 0", r); else passed++;
    endtask

    task automatic test_backpressure();
        ahb_write(A_CTRL, 32'h2);
        pix_out_ready = 1'b0;
        pix_in_valid = 1'b1; pix_in_sof = 1'b1; pix_in_data = 24'h101010;
        tick();
        pix_in_sof = 1'b0; pix_in_data = 24'h301005;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pix_in_ready !== 1'b0 || pix_out_valid !== 1'b1 || pix_out_data !== 24'h10A510)
                $display("FAIL stall_cycle%0d: got in_ready=%b valid=%b data=%h expected 0 1 10a510",
                         i, pix_in_ready, pix_out_valid, pix_out_data);
            else passed++;
            tick();
        end
        pix_out_ready = 1'b1;
        tick();
        pix_in_valid = 1'b0;
        checks++;
        if (pix_out_valid !== 1'b1 || pix_out_data !== 24'h30A505 || pix_out_sof !== 1'b0)
            $display("FAIL stall_release: got valid=%b data=%h sof=%b expected 1 30a505 0",
                     pix_out_valid, pix_out_data, pix_out_sof);
        else passed++;
        tick();
        checks++;
        if (pix_out_valid !== 1'b0)
            $display("FAIL stall_drain: got valid=%b expected 0", pix_out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int errs;
        for (int i = 0; i < 256; i++) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_CH2 | (32'(i) << 2);
            if (i > 0) HWDATA = 32'(255 - (i - 1));
            tick();
        end
        HWRITE = 1'b0; HADDR = A_CH2 | (32'd255 << 2); HWDATA = 32'h0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        checks++;
        if (HRDATA !== 32'h0) $display("FAIL read_after_write: got %h expected 0", HRDATA);
        else passed++;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            ahb_read(A_CH2 | (32'(i) << 2), r);
            if (r !== 32'(255 - i)) begin
                errs++;
                $display("FAIL burst_entry%0d: got %h expected %h", i, r, 32'(255 - i));
            end
        end
        checks++;
        if (errs == 0) passed++;
        ahb_write(A_BAD | (32'h10 << 2), 32'h77);
        ahb_read(A_BAD | (32'h10 << 2), r);
        checks++;
        if (r !== 32'h0) $display("FAIL bad_region: got %h expected 0", r); else passed++;
        ahb_read(A_CH0 | (32'h10 << 2), r);
        checks++;
        if (r !== 32'h10) $display("FAIL ch0_untouched: got %h expected 10", r); else passed++;
        ahb_write(A_CTRL, 32'h7);
        send_pix("all_channels", 24'h101010, 1'b1, 24'hEFA510);
    endtask

    task automatic test_collision();
        ahb_write(A_CTRL, 32'h1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_CH0 | (32'h20 << 2);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55;
        pix_out_ready = 1'b1; pix_in_valid = 1'b1; pix_in_sof = 1'b1; pix_in_data = 24'h000020;
        tick();
        pix_in_sof = 1'b0;
        checks++;
        if (pix_out_data !== 24'h000020)
            $display("FAIL collision_old: got %h expected 000020", pix_out_data);
        else passed++;
        tick();
        pix_in_valid = 1'b0;
        checks++;
        if (pix_out_data !== 24'h000055)
            $display("FAIL collision_new: got %h expected 000055", pix_out_data);
        else passed++;
        tick();
    endtask

    task automatic test_reset_midop();
        logic [31:0] r;
        ahb_write(A_CTRL, 32'h3);
        pix_out_ready = 1'b0;
        pix_in_valid = 1'b1; pix_in_sof = 1'b1; pix_in_data = 24'h101010;
        tick();
        pix_in_valid = 1'b0; pix_in_sof = 1'b0;
        checks++;
        if (pix_out_valid !== 1'b1 || pix_out_data !== 24'h10A510)
            $display("FAIL stalled_before_reset: got valid=%b data=%h expected 1 10a510",
                     pix_out_valid, pix_out_data);
        else passed++;
        #2 HRESET = 1'b1;
        #1;
        checks++;
        if (pix_out_valid !== 1'b0 || pix_out_data !== '0 || pix_out_sof !== 1'b0)
            $display("FAIL async_reset: got valid=%b data=%h sof=%b expected 0 0 0",
                     pix_out_valid, pix_out_data, pix_out_sof);
        else passed++;
        tick();
        tick();
        HRESET = 1'b0;
        pix_out_ready = 1'b1;
        ahb_read(A_CTRL, r);
        checks++;
        if (r !== 32'h0) $display("FAIL ctrl_after_reset: got %h expected 0", r); else passed++;
        ahb_read(A_CH1 | (32'h10 << 2), r);
        checks++;
        if (r !== 32'h10) $display("FAIL ch1_identity: got %h expected 10", r); else passed++;
        ahb_read(A_CH2 | (32'h10 << 2), r);
        checks++;
        if (r !== 32'h10) $display("FAIL ch2_identity: got %h expected 10", r); else passed++;
        ahb_read(A_CH0 | (32'h20 << 2), r);
        checks++;
        if (r !== 32'h20) $display("FAIL ch0_identity: got %h expected 20", r); else passed++;
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010; HPROT = 4'h0;
        HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
        pix_in_valid = 1'b0; pix_in_sof = 1'b0; pix_in_data = '0; pix_out_ready = 1'b1;
        tick(); tick(); tick();
        HRESET = 1'b0;
        test_reset();
        test_lut_correction();
        test_midframe_ctrl();
        test_backpressure();
        test_back_to_back();
        test_collision();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
